// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port RAM (port A read/write, port B read-only) with a
// self-clearing sequence that zeroes every word after reset release or on a
// clear request. Read data on both ports is registered (one cycle latency)
// and held at zero while the clear sequence runs.
//
// Optional feature macro: RAM_DP_CLR_PARITY_EN
//   When defined, every word carries one extra even-parity bit, written as
//   ^data_in ^ parity_inj. A parity_err_a / parity_err_b flag is registered
//   alongside each port's read data. When undefined, the word is exactly
//   DATA_W bits and the parity ports do not exist.
module ram_dp_clr #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RDW_MODE = 0     // 0: same-address read returns old word, 1: returns new data
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_b,
    input  logic              clear,
    output logic              busy
`ifdef RAM_DP_CLR_PARITY_EN
    ,
    input  logic              parity_inj,
    output logic              parity_err_a,
    output logic              parity_err_b
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_DP_CLR_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int N_RD   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;

    // Storage array; no reset so it maps onto block RAM.
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                in_clear;
    logic                reads_valid;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   wr_word_idle;

    logic [ADDR_W-1:0]   rd_addr [N_RD];
    logic [DATA_W-1:0]   rd_data [N_RD];
`ifdef RAM_DP_CLR_PARITY_EN
    logic                rd_perr [N_RD];
`endif

    assign in_clear = (state_q == ST_CLEAR);

    // Reads only produce data in a cycle that stays in IDLE; the cycle that
    // launches a clear already returns zero so outputs are 0 for all of busy.
    assign reads_valid = (state_q == ST_IDLE) && !clear;

    // Word presented by port A in IDLE, including its parity bit if enabled.
`ifdef RAM_DP_CLR_PARITY_EN
    assign wr_word_idle = {(^data_in) ^ parity_inj, data_in};
`else
    assign wr_word_idle = data_in;
`endif

    // The clear sequence owns the write port; user writes are dropped meanwhile.
    assign wr_en   = in_clear || write;
    assign wr_addr = in_clear ? cnt_q : addr_a;
    assign wr_word = in_clear ? '0 : wr_word_idle;

    assign rd_addr[0] = addr_a;
    assign rd_addr[1] = addr_b;

    // Clear FSM: reset parks it in CLEAR at address 0, so a full sweep always
    // follows reset release; clear requests during a sweep are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Single write port shared by the clear sweep and user port A.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // One registered read path per port; both ports follow the same
    // read-during-write policy against the port A write.
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic              hit;
        logic [WORD_W-1:0] word_rd;
        logic [DATA_W-1:0] data_q;

        assign hit     = (RDW_MODE == 1) && write && (rd_addr[gi] == addr_a);
        assign word_rd = hit ? wr_word_idle : mem[rd_addr[gi]];

        // Capture read data; zero during reset and while clearing.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (reads_valid) begin
                data_q <= word_rd[DATA_W-1:0];
            end else begin
                data_q <= '0;
            end
        end

        assign rd_data[gi] = data_q;

`ifdef RAM_DP_CLR_PARITY_EN
        logic perr_q;

        // Even parity over data plus stored bit; any odd count is an error.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                perr_q <= 1'b0;
            end else if (reads_valid) begin
                perr_q <= ^word_rd;
            end else begin
                perr_q <= 1'b0;
            end
        end

        assign rd_perr[gi] = perr_q;
`endif
    end

    assign data_a = rd_data[0];
    assign data_b = rd_data[1];
    assign busy   = busy_q;

`ifdef RAM_DP_CLR_PARITY_EN
    assign parity_err_a = rd_perr[0];
    assign parity_err_b = rd_perr[1];
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Testbench for ram_dp_clr (DATA_W=8, ADDR_W=4): directed vector table,
// hand-written clear/reset sequences and randomized traffic checked against
// a behavioural memory model.
module tb_ram_dp_clr;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int RDW   = 0;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          write   = 1'b0;
    logic          clear   = 1'b0;
    logic [AW-1:0] addr_a  = '0;
    logic [AW-1:0] addr_b  = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          busy;
`ifdef RAM_DP_CLR_PARITY_EN
    logic          parity_inj = 1'b0;
    logic          parity_err_a;
    logic          parity_err_b;
`endif

    always #5 clk = ~clk;

    ram_dp_clr #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RDW_MODE(RDW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .write   (write),
        .addr_a  (addr_a),
        .data_in (data_in),
        .data_a  (data_a),
        .addr_b  (addr_b),
        .data_b  (data_b),
        .clear   (clear),
        .busy    (busy)
`ifdef RAM_DP_CLR_PARITY_EN
        ,
        .parity_inj  (parity_inj),
        .parity_err_a(parity_err_a),
        .parity_err_b(parity_err_b)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: word contents plus remaining clear cycles.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr_left = DEPTH;
    logic [DW-1:0] e_a, e_b;
    logic          e_busy;
`ifdef RAM_DP_CLR_PARITY_EN
    logic          m_pe [DEPTH];
    logic          e_pa, e_pb;
`endif

    typedef struct {
        bit w;
        int aa;
        int din;
        int ab;
        int ea;
        int eb;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
`ifdef RAM_DP_CLR_PARITY_EN
            m_pe[i] = 1'b0;
`endif
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic cycle(input bit w, input int aa, input int din, input int ab,
                         input bit clr, input bit inj);
        logic [DW-1:0] ra, rb;
        write   = w;
        addr_a  = aa[AW-1:0];
        addr_b  = ab[AW-1:0];
        data_in = din[DW-1:0];
        clear   = clr;
`ifdef RAM_DP_CLR_PARITY_EN
        parity_inj = inj;
`endif
        if (!reset_n) begin
            m_clr_left = DEPTH;
            model_zero();
            e_busy = 1'b1; e_a = '0; e_b = '0;
`ifdef RAM_DP_CLR_PARITY_EN
            e_pa = 1'b0; e_pb = 1'b0;
`endif
        end else if (m_clr_left > 0) begin
            m_clr_left--;
            e_busy = (m_clr_left > 0); e_a = '0; e_b = '0;
`ifdef RAM_DP_CLR_PARITY_EN
            e_pa = 1'b0; e_pb = 1'b0;
`endif
        end else begin
            ra = (RDW == 1 && w) ? din[DW-1:0] : m_mem[aa[AW-1:0]];
            rb = (RDW == 1 && w && ab[AW-1:0] == aa[AW-1:0]) ? din[DW-1:0] : m_mem[ab[AW-1:0]];
`ifdef RAM_DP_CLR_PARITY_EN
            e_pa = clr ? 1'b0 : ((RDW == 1 && w) ? inj : m_pe[aa[AW-1:0]]);
            e_pb = clr ? 1'b0 : ((RDW == 1 && w && ab[AW-1:0] == aa[AW-1:0]) ? inj : m_pe[ab[AW-1:0]]);
            if (w) m_pe[aa[AW-1:0]] = inj;
`endif
            if (w) m_mem[aa[AW-1:0]] = din[DW-1:0];
            if (clr) begin
                m_clr_left = DEPTH;
                model_zero();
            end
            e_busy = clr;
            e_a = clr ? '0 : ra;
            e_b = clr ? '0 : rb;
        end
        @(posedge clk);
        #1;
        chk("busy", busy, e_busy);
        chk("data_a", data_a, e_a);
        chk("data_b", data_b, e_b);
`ifdef RAM_DP_CLR_PARITY_EN
        chk("parity_err_a", parity_err_a, e_pa);
        chk("parity_err_b", parity_err_b, e_pb);
`endif
        $display("t=%0t w=%0d aa=%0d din=%02h ab=%0d clr=%0d -> busy=%0d a=%02h b=%02h",
                 $time, w, aa, din, ab, clr, busy, data_a, data_b);
    endtask

    // Run idle cycles until busy drops, returning the number of edges taken.
    task automatic wait_clear_done(output int n);
        n = 0;
        do begin
            cycle(0, 0, 0, 0, 0, 0);
            n++;
        end while (busy && n < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_zero();

        // Reset held, then released: exactly 16 clear cycles, all words zero.
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        wait_clear_done(n);
        chk("reset_clear_len", n, 16);
        for (int i = 0; i < DEPTH; i++) cycle(0, i, 0, DEPTH - 1 - i, 0, 0);

        // Directed table: dual read and read-during-write.
        tbl[0] = '{1, 3, 'hA5, 0, (RDW == 1) ? 'hA5 : 'h00, 'h00};
        tbl[1] = '{1, 7, 'h5A, 3, (RDW == 1) ? 'h5A : 'h00, 'hA5};
        tbl[2] = '{0, 3, 'h00, 7, 'hA5, 'h5A};
        tbl[3] = '{1, 5, 'h11, 0, (RDW == 1) ? 'h11 : 'h00, 'h00};
        tbl[4] = '{1, 5, 'h22, 5, (RDW == 1) ? 'h22 : 'h11, (RDW == 1) ? 'h22 : 'h11};
        tbl[5] = '{0, 5, 'h00, 5, 'h22, 'h22};
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].w, tbl[i].aa, tbl[i].din, tbl[i].ab, 0, 0);
            chk($sformatf("vec%0d_a", i), data_a, tbl[i].ea);
            chk($sformatf("vec%0d_b", i), data_b, tbl[i].eb);
        end

        // Asynchronous reset while data_a is non-zero, then full re-clear.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_data_a", data_a, 0);
        chk("rst_async_data_b", data_b, 0);
        chk("rst_async_busy", busy, 1);
        repeat (2) cycle(1, 5, 'h99, 5, 0, 0);
        reset_n = 1'b1;
        wait_clear_done(n);
        chk("rst_reclear_len", n, 16);
        cycle(0, 5, 0, 3, 0, 0);
        chk("rst_reclear_word5", data_a, 0);

        // Clear pulse; write and a second clear during the sweep are ignored.
        cycle(1, 2, 'h77, 0, 0, 0);
        cycle(0, 2, 0, 2, 0, 0);
        chk("pre_clear_word2", data_a, 'h77);
        cycle(0, 0, 0, 0, 1, 0);
        n = 0;
        do begin
            cycle(n == 3, 2, 'hFF, 2, n == 6, 0);
            n++;
        end while (busy && n < 40);
        chk("clear_len_no_restart", n, 16);
        cycle(0, 2, 0, 2, 0, 0);
        chk("clear_word2_a", data_a, 0);
        chk("clear_word2_b", data_b, 0);

        // Reset asserted at clear cycle 5; sweep restarts from scratch.
        cycle(1, 9, 'h3E, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        repeat (5) cycle(0, 9, 0, 9, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midclr_rst_busy", busy, 1);
        chk("midclr_rst_data_a", data_a, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        wait_clear_done(n);
        chk("midclr_reclear_len", n, 16);

`ifdef RAM_DP_CLR_PARITY_EN
        // Parity injection then clean rewrite.
        cycle(1, 1, 'h3C, 0, 0, 1);
        cycle(0, 1, 0, 1, 0, 0);
        chk("par_inj_data_a", data_a, 'h3C);
        chk("par_inj_err_a", parity_err_a, 1);
        cycle(1, 1, 'h3C, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        chk("par_clean_err_a", parity_err_a, 0);
`endif

        // Randomized traffic against the model, with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, 49) == 0, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
